// File: rtl/count_capture_pkg.sv
// Shared defaults, drop-counter sizing and the capture entry layout for count_capture.
package count_capture_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 4;

    localparam int                DROP_W   = 8;
    localparam logic [DROP_W-1:0] DROP_MAX = 8'd255;

    // Entry layout at the default width; the top re-declares it at its own WIDTH.
    typedef struct packed {
        logic [DEF_WIDTH-1:0] data;
        logic [DEF_WIDTH-1:0] delta;
    } entry_t;

endpackage

// File: rtl/count_capture_fifo.sv
// Capture FIFO: storage, wrapping pointers, occupancy and push/pop/full/empty decisions.
module count_capture_fifo
    import count_capture_pkg::*;
#(
    parameter int  DEPTH = DEF_DEPTH,
    parameter type T     = entry_t,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  T            wdata,
    input  logic        ready,
    output T            rdata,
    output logic        valid,
    output logic        accept,
    output logic        pop,
    output logic [AW:0] level
);

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    T            mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic          full;

    assign valid = (level != '0);
    assign full  = (level == FULL_LVL);
    assign pop   = valid & ready;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign accept = push & (~full | pop);
    assign rdata  = valid ? mem[rptr] : '0;

    always_ff @(posedge clk) begin
        if (accept)
            mem[wptr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (accept)
                wptr <= wptr + AW'(1);
            if (pop)
                rptr <= rptr + AW'(1);
            case ({accept, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/count_capture.sv
// Captures count_in on each evt rising edge into a FIFO together with the delta
// from the previous accepted capture; tracks dropped captures.
module count_capture
    import count_capture_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         count_in,
    input  logic                     evt,
    input  logic                     out_ready,
    input  logic                     clr_ovf,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic [WIDTH-1:0]         out_delta,
    output logic                     overflow,
    output logic [DROP_W-1:0]        drop_cnt,
    output logic [$clog2(DEPTH):0]   level
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [WIDTH-1:0] delta;
    } cap_t;

    logic             evt_q;
    logic             det;
    logic             accept;
    logic             pop;
    logic             drop;
    logic [WIDTH-1:0] last_acc;
    cap_t             wentry, head;

    assign det          = evt & ~evt_q;
    assign wentry.data  = count_in;
    assign wentry.delta = count_in - last_acc;
    assign drop         = det & ~accept;

    count_capture_fifo #(
        .DEPTH (DEPTH),
        .T     (cap_t)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (det),
        .wdata  (wentry),
        .ready  (out_ready),
        .rdata  (head),
        .valid  (out_valid),
        .accept (accept),
        .pop    (pop),
        .level  (level)
    );

    assign out_data  = head.data;
    assign out_delta = head.delta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_q    <= 1'b0;
            last_acc <= '0;
        end else begin
            evt_q <= evt;
            if (accept)
                last_acc <= count_in;
        end
    end

    // A drop in the same cycle as a clear wins: the flag stays set and counts this one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (clr_ovf) begin
            overflow <= drop;
            drop_cnt <= drop ? DROP_W'(1) : '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != DROP_MAX)
                drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_count_capture.sv
// Directed bench for count_capture: hand-computed vectors checked with immediate assertions.
module tb_count_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] count_in;
    logic        evt;
    logic        out_ready;
    logic        clr_ovf;
    logic        out_valid;
    logic [31:0] out_data;
    logic [31:0] out_delta;
    logic        overflow;
    logic [7:0]  drop_cnt;
    logic [2:0]  level;

    int vectors     = 0;
    int miscompares = 0;

    count_capture dut (
        .clk       (clk),
        .rst       (rst),
        .count_in  (count_in),
        .evt       (evt),
        .out_ready (out_ready),
        .clr_ovf   (clr_ovf),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_delta (out_delta),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt),
        .level     (level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input logic [31:0] c);
        count_in = c;
        evt = 1'b1;
        tick();
        evt = 1'b0;
        tick();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; count_in = '0; evt = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
        #2;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_delta", out_delta, 32'd0);
        tick();
        rst = 1'b0;

        // single capture, 1-cycle latency
        count_in = 32'd100; evt = 1'b1; out_ready = 1'b1;
        tick();
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_data", out_data, 32'd100);
        chk("single_delta", out_delta, 32'd100);
        evt = 1'b0;
        tick();
        chk("single_drain_level", 32'(level), 32'd0);
        chk("single_drain_valid", 32'(out_valid), 32'd0);

        // backpressure from a clean last_acc
        pulse_reset();
        out_ready = 1'b0;
        capture(32'd10); capture(32'd20); capture(32'd30); capture(32'd40);
        chk("bp_level4", 32'(level), 32'd4);
        chk("bp_ovf_before", 32'(overflow), 32'd0);
        capture(32'd50);
        chk("bp_level_full", 32'(level), 32'd4);
        chk("bp_ovf", 32'(overflow), 32'd1);
        chk("bp_drop", 32'(drop_cnt), 32'd1);
        tick();
        chk("bp_hold_data", out_data, 32'd10);
        chk("bp_hold_delta", out_delta, 32'd10);

        // full with simultaneous pop: 60 accepted, delta against 40 (50 was dropped)
        out_ready = 1'b1; count_in = 32'd60; evt = 1'b1;
        tick();
        evt = 1'b0;
        chk("fullpop_level", 32'(level), 32'd4);
        chk("fullpop_drop", 32'(drop_cnt), 32'd1);
        chk("drain_data20", out_data, 32'd20);
        chk("drain_delta20", out_delta, 32'd10);
        tick();
        chk("drain_data30", out_data, 32'd30);
        chk("drain_delta30", out_delta, 32'd10);
        tick();
        chk("drain_data40", out_data, 32'd40);
        chk("drain_delta40", out_delta, 32'd10);
        tick();
        chk("fullpop_data", out_data, 32'd60);
        chk("fullpop_delta", out_delta, 32'd20);
        tick();
        chk("drain_empty", 32'(out_valid), 32'd0);

        // counter wrap
        count_in = 32'hFFFF_FFFE; evt = 1'b1;
        tick();
        chk("wrap_data1", out_data, 32'hFFFF_FFFE);
        chk("wrap_delta1", out_delta, 32'hFFFF_FFC2);
        evt = 1'b0;
        tick();
        count_in = 32'h0000_0003; evt = 1'b1;
        tick();
        chk("wrap_data2", out_data, 32'h0000_0003);
        chk("wrap_delta2", out_delta, 32'd5);
        evt = 1'b0;
        tick();
        chk("wrap_empty", 32'(level), 32'd0);

        // clear colliding with a drop, then saturation
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("clr_ovf", 32'(overflow), 32'd0);
        chk("clr_drop", 32'(drop_cnt), 32'd0);
        out_ready = 1'b0;
        capture(32'd1); capture(32'd2); capture(32'd3); capture(32'd4);
        count_in = 32'd5; evt = 1'b1; clr_ovf = 1'b1;
        tick();
        evt = 1'b0; clr_ovf = 1'b0;
        chk("clrdrop_ovf", 32'(overflow), 32'd1);
        chk("clrdrop_cnt", 32'(drop_cnt), 32'd1);
        tick();
        for (int i = 0; i < 253; i++) capture(32'(i + 6));
        chk("drop_254", 32'(drop_cnt), 32'd254);
        for (int i = 0; i < 47; i++) capture(32'(i + 300));
        chk("drop_sat", 32'(drop_cnt), 32'd255);
        chk("drop_sat_ovf", 32'(overflow), 32'd1);
        chk("drop_sat_level", 32'(level), 32'd4);

        // asynchronous reset with level=3, evt already high at release
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("prerst_level", 32'(level), 32'd3);
        evt = 1'b1; count_in = 32'd77;
        #2 rst = 1'b1;
        #1;
        chk("async_valid", 32'(out_valid), 32'd0);
        chk("async_level", 32'(level), 32'd0);
        chk("async_data", out_data, 32'd0);
        chk("async_ovf", 32'(overflow), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("postrst_level", 32'(level), 32'd1);
        chk("postrst_data", out_data, 32'd77);
        chk("postrst_delta", out_delta, 32'd77);
        count_in = 32'd78;
        tick(); tick(); tick();
        chk("held_evt_level", 32'(level), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/count_capture.md
COUNT_CAPTURE -- requirements
Module: count_capture

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the width of the count input, the captured data and the delta.
REQ-002 Parameter DEPTH, default 4 (power of two, ≥2), SHALL set the number of capture FIFO entries.
REQ-003 clk  input  1  SHALL be the single rising-edge clock for all state.
REQ-004 rst  input  1  SHALL be the reset: asynchronous and active-high.
REQ-005 count_in  input  WIDTH  SHALL carry the free-running counter value from the upstream counter, synchronous to clk.
REQ-006 evt  input  1  SHALL be the event level, synchronous to clk; each rising edge requests one capture.
REQ-007 out_ready  input  1  SHALL be the consumer ready signal.
REQ-008 clr_ovf  input  1  SHALL clear the sticky overflow flag and the drop counter when high.
REQ-009 out_valid  output  1  SHALL indicate that the FIFO head is valid.
REQ-010 out_data  output  WIDTH  SHALL carry the captured count_in of the FIFO head.
REQ-011 out_delta  output  WIDTH  SHALL carry the head capture minus the previous accepted capture, modulo 2^WIDTH.
REQ-012 overflow  output  1  SHALL be the sticky flag indicating that a capture was dropped.
REQ-013 drop_cnt  output  8  SHALL count dropped captures, saturating.
REQ-014 level  output  $clog2(DEPTH)+1  SHALL give the current FIFO occupancy.

Function
REQ-015 evt SHALL be registered once (evt_q); a capture SHALL be detected in cycle N when evt=1 and evt_q=0.
REQ-016 On detection in cycle N, the entry SHALL be {count_in sampled in cycle N, count_in minus last_acc}.
- last_acc is the value of the last accepted capture, 0 after reset.
REQ-017 An accepted entry SHALL be written at the clk edge ending cycle N; if the FIFO was empty, out_valid SHALL be 1 in cycle N+1 (1-cycle latency).
REQ-018 A pop SHALL occur exactly when out_valid=1 and out_ready=1.
REQ-019 out_data and out_delta SHALL hold stable while out_valid=1 and out_ready=0.
REQ-020 A detection SHALL be accepted when level<DEPTH, or when level=DEPTH and a pop occurs in the same cycle.
- In the accepted case, last_acc SHALL update to the captured value.
REQ-021 A detection when level=DEPTH with no pop SHALL be dropped.
- overflow SHALL be set.
- drop_cnt SHALL increment, saturating at 255.
- last_acc SHALL remain unchanged.
REQ-022 Push and pop in the same cycle SHALL leave level unchanged at any occupancy.
REQ-023 A pop when level=0 SHALL be impossible, because out_valid=0 when level=0.
REQ-024 count_in wrap-around (all-ones to 0) SHALL be captured verbatim; out_delta SHALL use modular subtraction, so a delta across the wrap is correct.
REQ-025 If clr_ovf=1 and a drop occur in the same cycle, overflow SHALL end at 1 and drop_cnt SHALL end at 1.
REQ-026 evt held high SHALL produce exactly one capture per rising edge.
REQ-027 FIFO read and write pointers SHALL be $clog2(DEPTH) bits wide and wrap modulo DEPTH.

Reset
REQ-028 While rst=1, the block SHALL clear all of the following:
- out_valid=0, level=0, overflow=0, drop_cnt=0;
- both FIFO pointers=0, last_acc=0, evt_q=0.
REQ-029 out_data and out_delta SHALL read 0 during reset; FIFO storage contents need not be reset.
REQ-030 rst asserted mid-operation SHALL discard all pending entries immediately (asynchronously).
REQ-031 An evt already high at reset release SHALL trigger a capture in the first cycle after release, because evt_q=0.

Structure
REQ-032 Package count_capture_pkg SHALL hold the following:
- default WIDTH and DEPTH;
- the drop counter width (8) and its saturation value (255);
- the FIFO entry struct {data, delta}.
REQ-033 A single sub-module count_capture_fifo SHALL implement the FIFO.
- It SHALL contain the storage, the pointers, level, and the push/pop/full/empty logic.
- Edge detection, delta calculation, last_acc and overflow/drop_cnt logic SHALL live in the top module.

Verification
REQ-034 The bench SHALL cover each of the following directed scenarios:
- Single capture: count_in=100 when the evt rising edge is detected, out_ready=1 → out_valid=1 one cycle later, out_data=100, out_delta=100, then level returns to 0.
- Backpressure: out_ready=0, edges detected at counts 10, 20, 30, 40, 50 → level=4, overflow=1, drop_cnt=1; draining gives data 10/20/30/40 and deltas 10/10/10/10.
- Full with simultaneous pop: level=4, out_ready=1, edge detected at count 60 → accepted, level stays 4; the new entry has delta 60−(last accepted capture).
- Wrap: captures at 32'hFFFFFFFE and then at 32'h00000003 → second out_delta=5.
- clr_ovf with a drop in the same cycle → overflow=1, drop_cnt=1; 300 further drops → drop_cnt=255.
- rst pulsed with level=3 → out_valid=0 and level=0 asynchronously; the next capture yields delta = data.
